// File: rtl/dffn_reg_arbiter.sv
// dffn_reg_arbiter
//   Round-robin write arbiter for one WIDTH-bit register shared by NREQ requesters.
//   All state changes happen on the falling edge of ck, and reset is asynchronous.
//   A grant is issued one negedge before the write. The write is acknowledged with a
//   one-cycle ack pulse. The stored value is then held for HOLD_CYC negedges before
//   the arbiter accepts another request.
//   Build option ARB_FIXED_PRI_EN: when defined, the lowest-index requester always wins,
//   and the last-winner pointer is not built.
module dffn_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 1
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [2:0]            owner,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] next_win;
    logic [3:0]       hold_cnt;

`ifdef ARB_FIXED_PRI_EN
    // Fixed priority: the lowest set index wins.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NREQ-1:0] r);
        logic [IDX_W-1:0] w;
        w = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r[i]) w = IDX_W'(i);
        end
        return w;
    endfunction

    // Winner candidate for the next IDLE negedge.
    always_comb next_win = pick_winner(req);
`else
    logic [IDX_W-1:0] last;

    // Round robin. The search distance from ptr+1, wrapping at NREQ, decides the winner,
    // so the first set bit after the previous winner is picked.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                     input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] w;
        int               best;
        int               d;
        w    = '0;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr) - 1;
            if (d < 0) d = d + NREQ;
            if (r[i] && (d < best)) begin
                best = d;
                w    = IDX_W'(i);
            end
        end
        return w;
    endfunction

    // Winner candidate for the next IDLE negedge.
    always_comb next_win = pick_winner(req, last);
`endif

    // busy mirrors the registered state, so it also clears as soon as reset is asserted.
    assign busy = (state != IDLE);

    // Arbitration FSM and the shared falling-edge register.
    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            win      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
            owner    <= '0;
`ifndef ARB_FIXED_PRI_EN
            last     <= IDX_W'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        win   <= next_win;
                        gnt   <= ONE << next_win;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    if (req[win]) begin
                        q        <= data[int'(win)*WIDTH +: WIDTH];
                        owner    <= 3'(win);
                        ack      <= ONE << win;
                        hold_cnt <= 4'(HOLD_CYC);
`ifndef ARB_FIXED_PRI_EN
                        last     <= win;
`endif
                        state    <= HOLD;
                    end else begin
                        // The requester withdrew: no write, no ack, and the pointer stays put.
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    ack      <= '0;
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt <= 4'd1) state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffn_reg_arbiter.sv
// Testbench for dffn_reg_arbiter (NREQ=4, WIDTH=8, HOLD_CYC=1).
// Stimulus is driven after each falling edge, or in the middle of a cycle.
// The outputs are checked 1 time unit after every falling edge against a transaction-level
// model of the arbiter's rules.
module tb_dffn_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int HOLD_CYC = 1;

    logic             ck = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] q;
    logic [2:0]       owner;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    dffn_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYC(HOLD_CYC)) dut (
        .ck(ck), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy)
    );

    // The first falling edge is at t=100.
    initial forever #50 ck = ~ck;

    // ---------------- reference model ----------------
    // -1 means no grant (or no ack) is outstanding.
    int              m_gnt;
    int              m_ack;
    int              m_hold;
    int              m_last;
    int              m_owner;
    logic [WIDTH-1:0] m_q;

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef ARB_FIXED_PRI_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int i);
        return (i < 0) ? 32'd0 : (32'd1 << i);
    endfunction

    task automatic model_reset();
        m_gnt = -1; m_ack = -1; m_hold = 0; m_last = NREQ - 1; m_owner = 0; m_q = '0;
    endtask

    task automatic model_step();
        if (m_gnt >= 0) begin
            if (req[m_gnt]) begin
                m_q     = data[m_gnt*WIDTH +: WIDTH];
                m_owner = m_gnt;
                m_last  = m_gnt;
                m_ack   = m_gnt;
                m_hold  = HOLD_CYC;
            end
            m_gnt = -1;
        end else if (m_hold > 0) begin
            m_ack  = -1;
            m_hold = m_hold - 1;
        end else if (req != '0) begin
            m_gnt = pick(req, m_last);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},     32'(q),     32'(m_q));
        check({tag, ".gnt"},   32'(gnt),   onehot(m_gnt));
        check({tag, ".ack"},   32'(ack),   onehot(m_ack));
        check({tag, ".owner"}, 32'(owner), 32'(m_owner));
        check({tag, ".busy"},  32'(busy),  32'((m_gnt >= 0) || (m_hold > 0)));
        check({tag, ".excl"},  32'((gnt != '0) && (ack != '0)), 32'd0);
    endtask

    task automatic tick(input string tag);
        @(negedge ck);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Reset pulse in the middle of a cycle. The outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        #20 rst_n = 1'b0;
        model_reset();
        #1 check_all(tag);
        #5 rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] wq[$];
    int               wt[$];
    logic [WIDTH-1:0] exp_seq[5];
    int               cnt3;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        model_reset();

        // Reset state.
        #20 check_all("reset");
        #10 rst_n = 1'b1;

        // Single write from requester 0.
        data = 32'h0000_00A5;
        req  = 4'b0001;
        tick("single1");
        check("single1.gnt_dir", 32'(gnt), 32'h1);
        tick("single2");
        check("single2.q_dir",   32'(q),   32'hA5);
        check("single2.ack_dir", 32'(ack), 32'h1);
        req = '0;
        tick("single3");
        check("single3.busy_dir", 32'(busy), 32'h0);
        tick("idle");

        // Round robin with all four requesters held.
        mid_reset("rr.rst");
        req  = 4'b1111;
        data = 32'h4433_2211;
        for (int c = 0; c < 16; c++) begin
            tick("rr");
            if (ack != '0) begin
                wq.push_back(q);
                wt.push_back(c);
            end
        end
`ifdef ARB_FIXED_PRI_EN
        exp_seq = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif
        check("rr.count", 32'(wq.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (wq.size() > i) begin
                check("rr.seq", 32'(wq[i]), 32'(exp_seq[i]));
                if (i > 0) check("rr.gap", 32'(wt[i] - wt[i-1]), 32'd3);
            end
        end
        req = '0;
        for (int c = 0; c < 3; c++) tick("rr.drain");

        // Abort: requester 2 withdraws while it holds the grant.
        mid_reset("abort.rst");
        data = 32'h0000_005A;
        req  = 4'b0001;
        tick("abort.pre1");
        tick("abort.pre2");
        req = '0;
        tick("abort.pre3");
        req = 4'b0100;
        tick("abort.gnt");
        check("abort.gnt_dir", 32'(gnt), 32'h4);
        req = '0;
        tick("abort.drop");
        check("abort.ack_dir",  32'(ack),  32'h0);
        check("abort.q_dir",    32'(q),    32'h5A);
        check("abort.busy_dir", 32'(busy), 32'h0);
        req  = 4'b1010;
        data = 32'h0000_BB00;
        tick("abort.next");
        check("abort.next_dir", 32'(gnt), 32'h2);
        tick("abort.w1");
        tick("abort.w2");
        req  = 4'b0110;
        tick("abort.again");
        req = '0;
        tick("abort.w3");
        tick("abort.w4");

        // Asynchronous reset while the value is being held.
        data = 32'h0000_00A5;
        req  = 4'b0001;
        tick("hold.g");
        tick("hold.w");
        #48 rst_n = 1'b0;
        model_reset();
        #1;
        check("hold.q_async",    32'(q),    32'h0);
        check("hold.ack_async",  32'(ack),  32'h0);
        check("hold.busy_async", 32'(busy), 32'h0);
        check_all("hold.rst");
        #10 rst_n = 1'b1;
        req = '0;
        tick("hold.after1");
        tick("hold.after2");

        // Requesters 1 and 3 held together.
        req  = 4'b1010;
        data = 32'h7700_6600;
        cnt3 = 0;
        for (int c = 0; c < 12; c++) begin
            tick("pair");
            if (gnt[3]) cnt3++;
        end
`ifdef ARB_FIXED_PRI_EN
        check("pair.idx3", 32'(cnt3 > 0), 32'd0);
`else
        check("pair.idx3", 32'(cnt3 > 0), 32'd1);
`endif
        req = '0;
        for (int c = 0; c < 3; c++) tick("pair.drain");

        // Random requests, data and occasional mid-cycle resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) mid_reset("rnd.rst");
            req  = 4'($urandom_range(0, 15));
            data = $urandom;
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
